// File: rtl/axi_fifo_rr_arb_if.sv
// Requester/FIFO-side bundle of the round-robin FIFO write arbiter.
// master = arbiter view, slave = requesters plus FIFO.
interface axi_fifo_rr_arb_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0]            src_req;
    logic [NUM_SRC-1:0]            src_last;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_ack;
    logic                          fifo_wrReq;
    logic                          fifo_wrAck;
    logic [ID_W+DATA_WIDTH-1:0]    fifo_wdata;
    logic                          busy;
    logic [ID_W-1:0]               grant_id;
    logic                          timeout_pulse;

    modport master (
        input  src_req, src_last, src_data, fifo_wrAck,
        output src_ack, fifo_wrReq, fifo_wdata, busy, grant_id, timeout_pulse
    );

    modport slave (
        output src_req, src_last, src_data, fifo_wrAck,
        input  src_ack, fifo_wrReq, fifo_wdata, busy, grant_id, timeout_pulse
    );
endinterface

// File: rtl/axi_fifo_rr_arb.sv
// Round-robin burst arbiter onto one FIFO write port; 1-cycle arbitration, then beats pass combinationally.
// Backpressure: fifo_wrAck low stalls the owner without losing the grant; an idle owner is evicted after HOLD_TIMEOUT cycles.
module axi_fifo_rr_arb #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    axi_fifo_rr_arb_if.master    bus
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BC_W = $clog2(MAX_BURST) + 1;
    localparam int IC_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IC_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic                  sel_vld;
    logic [ID_W-1:0]       sel_id;
    logic                  own_req;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  locked;
    logic                  xfer;
    logic                  last_beat;
    logic                  hold_expired;
    logic                  release_grant;
    logic [ID_W-1:0]       owner_next;

    // Scan downward so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (bus.src_req[idx]) begin
                sel_vld = 1'b1;
                sel_id  = ID_W'(idx);
            end
        end
    end

    assign locked        = (state_q == LOCKED);
    assign own_req       = bus.src_req[owner_q];
    assign own_last      = bus.src_last[owner_q];
    assign own_data      = bus.src_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign xfer          = locked && own_req && bus.fifo_wrAck;
    assign last_beat     = own_last || (beat_cnt_q == BC_W'(MAX_BURST - 1));
    assign hold_expired  = locked && !own_req && (idle_cnt_q == IC_W'(HOLD_TIMEOUT - 1));
    assign release_grant = (xfer && last_beat) || hold_expired;
    assign owner_next    = (int'(owner_q) == NUM_SRC - 1) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d    = LOCKED;
                    owner_d    = sel_id;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (release_grant) begin
                    state_d    = IDLE;
                    rr_ptr_d   = owner_next;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end else begin
                    // A stalled owner still counts as active, so only a low request ages the hold timer.
                    if (own_req) idle_cnt_d = '0;
                    else         idle_cnt_d = idle_cnt_q + 1'b1;
                    if (xfer)    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        bus.src_ack       = '0;
        bus.fifo_wrReq    = 1'b0;
        bus.fifo_wdata    = '0;
        bus.timeout_pulse = 1'b0;
        bus.busy          = locked;
        bus.grant_id      = owner_q;
        if (locked) begin
            bus.fifo_wrReq       = own_req;
            bus.src_ack[owner_q] = bus.fifo_wrAck;
            bus.fifo_wdata       = {owner_q, own_data};
            bus.timeout_pulse    = hold_expired;
        end
    end
endmodule

// File: tb/tb_axi_fifo_rr_arb.sv
module tb_axi_fifo_rr_arb;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int MB  = 16;
    localparam int HT  = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    axi_fifo_rr_arb_if #(.NUM_SRC(N), .DATA_WIDTH(DW)) bus ();

    axi_fifo_rr_arb #(
        .NUM_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the port, where the next search starts,
    // beats moved in this burst, consecutive cycles the owner has been silent.
    bit m_locked;
    int m_owner, m_ptr, m_beats, m_silent;

    int nxfer = 0;
    int glog[$];
    bit prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_beats = 0; m_silent = 0;
        prev_busy = 1'b0;
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] last, input logic ack);
        bus.src_req    = req;
        bus.src_last   = last;
        bus.fifo_wrAck = ack;
        bus.src_data   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic compare_model();
        logic [N-1:0]      e_ack;
        logic [IDW+DW-1:0] e_wdata;
        logic              e_req, e_to;
        e_ack = '0; e_wdata = '0; e_req = 1'b0; e_to = 1'b0;
        if (m_locked) begin
            e_req          = bus.src_req[m_owner];
            e_ack[m_owner] = bus.fifo_wrAck;
            e_wdata        = {IDW'(m_owner), bus.src_data[m_owner*DW +: DW]};
            e_to           = !bus.src_req[m_owner] && (m_silent == HT - 1);
        end
        chk("wrReq",    64'(bus.fifo_wrReq),    64'(e_req));
        chk("src_ack",  64'(bus.src_ack),       64'(e_ack));
        chk("wdata",    64'(bus.fifo_wdata),    64'(e_wdata));
        chk("busy",     64'(bus.busy),          64'(m_locked));
        chk("grant_id", 64'(bus.grant_id),      64'(m_owner));
        chk("timeout",  64'(bus.timeout_pulse), 64'(e_to));
    endtask

    task automatic model_advance();
        bit rel;
        rel = 1'b0;
        if (!m_locked) begin
            for (int k = N - 1; k >= 0; k--)
                if (bus.src_req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (bus.src_req != 0) begin
                m_locked = 1'b1; m_beats = 0; m_silent = 0;
            end
        end else if (bus.src_req[m_owner]) begin
            m_silent = 0;
            if (bus.fifo_wrAck) begin
                m_beats++;
                if (bus.src_last[m_owner] || m_beats == MB) rel = 1'b1;
            end
        end else begin
            m_silent++;
            if (m_silent == HT) rel = 1'b1;
        end
        if (rel) begin
            m_locked = 1'b0; m_beats = 0; m_silent = 0; m_ptr = (m_owner + 1) % N;
        end
    endtask

    // Caller is at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        #1;
        compare_model();
        if (bus.fifo_wrReq && bus.fifo_wrAck) nxfer++;
        if (bus.busy && !prev_busy) glog.push_back(int'(bus.grant_id));
        prev_busy = bus.busy;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, g0;
        rstn = 1'b0;
        set_in('0, '0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_busy",  64'(bus.busy),       64'd0);
        chk("rst_gid",   64'(bus.grant_id),   64'd0);
        chk("rst_wrreq", 64'(bus.fifo_wrReq), 64'd0);
        rstn = 1'b1;

        // Single source 2, three beats, last on the third.
        set_in(4'b0100, 4'b0000, 1'b1);
        step();
        chk("s1_grant", 64'(bus.grant_id), 64'd2);
        chk("s1_busy",  64'(bus.busy),     64'd1);
        n0 = nxfer;
        step();
        chk("s1_wdata_id", 64'(bus.fifo_wdata[33:32]), 64'd2);
        step();
        set_in(4'b0100, 4'b0100, 1'b1);
        step();
        chk("s1_xfers",    64'(nxfer - n0), 64'd3);
        chk("s1_busy_off", 64'(bus.busy),   64'd0);
        set_in(4'b1011, 4'b1111, 1'b1);
        step();
        chk("s1_next_from3", 64'(bus.grant_id), 64'd3);
        step();

        // Everyone requesting single-beat bursts: strict rotation with one bubble each.
        set_in(4'b1111, 4'b1111, 1'b1);
        n0 = nxfer; g0 = glog.size();
        repeat (8) step();
        chk("s2_xfers8", 64'(nxfer - n0), 64'd4);
        repeat (2) step();
        chk("s2_grants", 64'(glog.size() - g0), 64'd5);
        for (int k = 0; k < 5; k++)
            if (g0 + k < glog.size()) chk("s2_order", 64'(glog[g0 + k]), 64'(k % N));

        // Source 1 alone, no last: cut at MAX_BURST, then re-granted after one bubble.
        set_in(4'b0010, 4'b0000, 1'b1);
        n0 = nxfer;
        repeat (MB + 1) step();
        chk("s3_xfers",    64'(nxfer - n0), 64'(MB));
        chk("s3_busy_off", 64'(bus.busy),   64'd0);
        step();
        chk("s3_regrant",  64'(bus.grant_id), 64'd1);
        set_in(4'b0010, 4'b0010, 1'b1);
        step();

        // Owner 0 goes silent: forced release on the HT-th silent cycle.
        set_in(4'b0001, 4'b0000, 1'b1);
        step();
        chk("s4_grant", 64'(bus.grant_id), 64'd0);
        set_in(4'b0000, 4'b0000, 1'b1);
        repeat (HT - 1) step();
        #1;
        chk("s4_pulse", 64'(bus.timeout_pulse), 64'd1);
        step();
        chk("s4_idle",  64'(bus.busy), 64'd0);
        set_in(4'b1011, 4'b1111, 1'b1);
        step();
        chk("s4_ptr1", 64'(bus.grant_id), 64'd1);
        step();

        // Stalled last beat: grant held, no timeout, released on first accept.
        set_in(4'b0100, 4'b0100, 1'b0);
        step();
        n0 = nxfer;
        repeat (10) step();
        chk("s5_hold",  64'(bus.busy),       64'd1);
        chk("s5_noxfr", 64'(nxfer - n0),     64'd0);
        set_in(4'b0100, 4'b0100, 1'b1);
        step();
        chk("s5_xfer",  64'(nxfer - n0),     64'd1);
        chk("s5_rel",   64'(bus.busy),       64'd0);

        // Asynchronous reset in the middle of a burst.
        set_in(4'b0100, 4'b0000, 1'b1);
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_busy",  64'(bus.busy),       64'd0);
        chk("s6_wrreq", 64'(bus.fifo_wrReq), 64'd0);
        chk("s6_ack",   64'(bus.src_ack),    64'd0);
        chk("s6_wdata", 64'(bus.fifo_wdata), 64'd0);
        chk("s6_gid",   64'(bus.grant_id),   64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        set_in(4'b1000, 4'b1000, 1'b1);
        step();
        chk("s6_grant3", 64'(bus.grant_id), 64'd3);
        step();

        // Random traffic against the model.
        repeat (600) begin
            set_in(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
